// File: rtl/act_packer_pkg.sv
// Shared types and sizing helpers for the activation frame packer.
// ACT_PACKER_ROUND_EN selects round-half-up requantisation.
package act_packer_pkg;

  typedef enum logic {
    IDLE,
    FILL
  } pack_state_e;

  function automatic int beats_f(int w, int h);
    return w * h;
  endfunction

  function automatic int cnt_bits_f(int beats);
    return $clog2(beats) + 1;
  endfunction

  function automatic int act_max_f(int bits);
    return (1 << bits) - 1;
  endfunction

  localparam int BEATS    = beats_f(32, 1);
  localparam int CNT_BITS = cnt_bits_f(BEATS);
  localparam int ACT_MAX  = act_max_f(8);

endpackage

// File: rtl/act_frame_packer_relu_requant.sv
// One-channel ReLU + saturating requantiser (combinational).
// ACT_PACKER_ROUND_EN adds round-half-up before the shift.
module relu_requant
  import act_packer_pkg::*;
#(
  parameter int ACC_BITS   = 32,
  parameter int ACTIV_BITS = 8,
  parameter int SHIFT      = 8
) (
  input  logic [ACC_BITS-1:0]   acc_i,
  output logic [ACTIV_BITS-1:0] act_o
);

  logic signed [ACC_BITS:0] ext;
  logic signed [ACC_BITS:0] biased;
  logic signed [ACC_BITS:0] shd;

  // one extra bit so the rounding add cannot overflow
  assign ext = {acc_i[ACC_BITS-1], acc_i};

`ifdef ACT_PACKER_ROUND_EN
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [ACC_BITS:0] ONE =
    {{ACC_BITS{1'b0}}, 1'b1};
  localparam logic [ACC_BITS:0] RND =
    (SHIFT > 0) ? (ONE << RS) : '0;
  assign biased = ext + $signed(RND);
`else
  assign biased = ext;
`endif

  assign shd = biased >>> SHIFT;

  always_comb begin
    if (acc_i[ACC_BITS-1])
      act_o = '0;
    else if (|shd[ACC_BITS:ACTIV_BITS])
      act_o = '1;
    else
      act_o = shd[ACTIV_BITS-1:0];
  end

endmodule

// File: rtl/act_frame_packer.sv
// Packs requantised beats into a flat frame for the max-pool stage.
// ACT_PACKER_ROUND_EN selects round-half-up requantisation.
module act_frame_packer
  import act_packer_pkg::*;
#(
  parameter int FRAME_WIDTH  = 32,
  parameter int FRAME_HEIGHT = 1,
  parameter int CHANNELS     = 8,
  parameter int ACC_BITS     = 32,
  parameter int ACTIV_BITS   = 8,
  parameter int SHIFT        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_sof,
  input  logic [CHANNELS*ACC_BITS-1:0] in_acc,
  output logic [FRAME_WIDTH*FRAME_HEIGHT*CHANNELS*ACTIV_BITS-1:0]
    frame_data,
  output logic frame_valid,
  output logic sync_err,
  input  logic err_clr,
  output logic [15:0] frame_count
);

  localparam int NB  = beats_f(FRAME_WIDTH, FRAME_HEIGHT);
  localparam int CB  = cnt_bits_f(NB);
  localparam int BW  = CHANNELS * ACTIV_BITS;
  localparam int FW  = NB * BW;
  localparam logic [CB-1:0] LAST = CB'(NB - 1);

  pack_state_e   state_q;
  logic [CB-1:0] cnt_q;
  logic [FW-1:0] data_q;
  logic          valid_q;
  logic          err_q;
  logic [15:0]   fcnt_q;

  logic [BW-1:0] beat_act;
  logic [CB-1:0] widx_d;
  logic          acc_ok;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    relu_requant #(
      .ACC_BITS  (ACC_BITS),
      .ACTIV_BITS(ACTIV_BITS),
      .SHIFT     (SHIFT)
    ) u_rq (
      .acc_i(in_acc[k*ACC_BITS +: ACC_BITS]),
      .act_o(beat_act[k*ACTIV_BITS +: ACTIV_BITS])
    );
  end

  assign in_ready = ~rst;
  assign acc_ok   = in_valid & in_ready;
  // a SOF beat always restarts at slot 0
  assign widx_d   = in_sof ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      if (err_clr)
        err_q <= 1'b0;
      if (acc_ok) begin
        if (state_q == IDLE && !in_sof) begin
          err_q <= 1'b1;
        end else begin
          if (state_q == FILL && in_sof)
            err_q <= 1'b1;
          data_q[widx_d*BW +: BW] <= beat_act;
          if (widx_d == LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            valid_q <= 1'b1;
            fcnt_q  <= fcnt_q + 16'd1;
          end else begin
            cnt_q   <= widx_d + 1'b1;
            state_q <= FILL;
          end
        end
      end
    end
  end

  assign frame_data  = data_q;
  assign frame_valid = valid_q;
  assign sync_err    = err_q;
  assign frame_count = fcnt_q;

endmodule

// File: tb/tb_act_frame_packer.sv
// Randomised self-checking bench for act_frame_packer
// against a frame-level reference model.
module tb_act_frame_packer;

  localparam int FWID = 4;
  localparam int FHGT = 1;
  localparam int CH   = 2;
  localparam int AB   = 32;
  localparam int OB   = 8;
  localparam int SH   = 4;
  localparam int NB   = FWID * FHGT;
  localparam int DW   = NB * CH * OB;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic in_sof;
  logic [CH*AB-1:0] in_acc;
  logic [DW-1:0] frame_data;
  logic frame_valid;
  logic sync_err;
  logic err_clr;
  logic [15:0] frame_count;

  act_frame_packer #(
    .FRAME_WIDTH (FWID),
    .FRAME_HEIGHT(FHGT),
    .CHANNELS    (CH),
    .ACC_BITS    (AB),
    .ACTIV_BITS  (OB),
    .SHIFT       (SH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_acc     (in_acc),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .sync_err   (sync_err),
    .err_clr    (err_clr),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string tag, logic [DW-1:0] got,
                       logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: frame image, beats collected (-1 = none)
  logic [DW-1:0] m_img;
  int m_pos;
  bit m_err;
  bit m_valid;
  int unsigned m_cnt;
  int n_strobe;

  function automatic int xf(int acc);
    longint v;
    if (acc < 0) return 0;
`ifdef ACT_PACKER_ROUND_EN
    v = (longint'(acc) + (1 << (SH - 1))) / (1 << SH);
`else
    v = longint'(acc) / (1 << SH);
`endif
    if (v > 255) return 255;
    return int'(v);
  endfunction

  task automatic step(bit r, bit v, bit sof, int a0, int a1,
                      bit clr);
    int acc[CH];
    acc[0] = a0;
    acc[1] = a1;
    rst      = r;
    in_valid = v;
    in_sof   = sof;
    in_acc   = {a1, a0};
    err_clr  = clr;
    m_valid  = 0;
    if (r) begin
      m_pos = -1;
      m_img = '0;
      m_err = 0;
      m_cnt = 0;
    end else begin
      if (clr) m_err = 0;
      if (v) begin
        if (sof) begin
          if (m_pos >= 0) m_err = 1;
          m_pos = 0;
        end
        if (m_pos < 0) begin
          m_err = 1;
        end else begin
          for (int k = 0; k < CH; k++)
            m_img[(m_pos*CH + k)*OB +: OB] = OB'(xf(acc[k]));
          m_pos++;
          if (m_pos == NB) begin
            m_valid = 1;
            m_cnt++;
            m_pos = -1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (frame_valid) n_strobe++;
    check("frame_valid", DW'(frame_valid), DW'(m_valid));
    check("frame_count", DW'(frame_count), DW'(m_cnt[15:0]));
    check("sync_err", DW'(sync_err), DW'(m_err));
    if (m_valid || r)
      check("frame_data", frame_data, m_img);
    #1;
    check("in_ready", DW'(in_ready), DW'(!r));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  int s0;
  int a0;
  int a1;
  bit sv;
  bit ss;

  initial begin
    rst = 1; in_valid = 0; in_sof = 0; in_acc = '0;
    err_clr = 0;
    m_pos = -1; m_img = '0; m_err = 0; m_cnt = 0;
    n_strobe = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_data", frame_data, '0);

    // nominal frame
    for (int n = 0; n < NB; n++)
      step(0, 1, n == 0, n * 16, -5, 0);
    check("nominal_img", frame_data, 64'h0003_0002_0001_0000);
    check("nominal_cnt", DW'(frame_count), DW'(1));
    idle(2);

    // saturation and rounding
    step(0, 1, 1, 4096, 23, 0);
    step(0, 1, 0, 24, -1, 0);
    step(0, 1, 0, 32'h7fff_ffff, 8, 0);
    step(0, 1, 0, 15, 4095, 0);
    check("sat_4096", DW'(frame_data[7:0]), DW'(255));
`ifdef ACT_PACKER_ROUND_EN
    check("rnd_24", DW'(frame_data[23:16]), DW'(2));
`else
    check("trn_24", DW'(frame_data[23:16]), DW'(1));
`endif
    check("rnd_23", DW'(frame_data[15:8]), DW'(1));
    idle(1);

    // back-to-back frames
    s0 = n_strobe;
    for (int n = 0; n < 2 * NB; n++)
      step(0, 1, (n % NB) == 0, n * 20, 100 - n, 0);
    check("b2b_strobes", DW'(n_strobe - s0), DW'(2));
    idle(1);

    // early SOF
    step(1, 0, 0, 0, 0, 0);
    s0 = n_strobe;
    step(0, 1, 1, 50, 60, 0);
    step(0, 1, 0, 70, 80, 0);
    step(0, 1, 1, 900, 1000, 0);
    for (int n = 1; n < NB; n++)
      step(0, 1, 0, n * 300, n * 7, 0);
    check("esof_strobes", DW'(n_strobe - s0), DW'(1));
    check("esof_cnt", DW'(frame_count), DW'(1));
    check("esof_err", DW'(sync_err), DW'(1));

    // stray beat in IDLE, then clear
    step(0, 0, 0, 0, 0, 1);
    check("clr_err", DW'(sync_err), DW'(0));
    s0 = n_strobe;
    step(0, 1, 0, 77, 77, 0);
    check("stray_err", DW'(sync_err), DW'(1));
    // clear and new error together: error wins
    step(0, 1, 0, 5, 5, 1);
    step(0, 0, 0, 0, 0, 1);
    check("stray_strobe", DW'(n_strobe - s0), DW'(0));

    // reset mid-frame
    step(0, 1, 1, 11, 12, 0);
    step(0, 1, 0, 13, 14, 0);
    s0 = n_strobe;
    step(1, 0, 0, 0, 0, 0);
    idle(1);
    for (int n = 0; n < NB; n++)
      step(0, 1, n == 0, n * 40, n * 41, 0);
    check("rst_strobes", DW'(n_strobe - s0), DW'(1));
    check("rst_cnt", DW'(frame_count), DW'(1));

    // randomised traffic
    for (int i = 0; i < 1500; i++) begin
      sv = ($urandom_range(3) != 0);
      ss = ($urandom_range(5) == 0);
      case ($urandom_range(3))
        0: a0 = int'($urandom);
        1: a0 = int'($urandom_range(5000)) - 500;
        default: a0 = int'($urandom_range(4200));
      endcase
      a1 = int'($urandom_range(8191)) - 2048;
      step($urandom_range(150) == 0, sv, ss, a0, a1,
           $urandom_range(15) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
